hex_dec_string_char_addr_gen: RTL and testbench
===============================================

// Module: hex_dec_string_char_addr_gen
// PURPOSE
//  Converts an unsigned VALUE_WIDTH-bit value into NUM_CHARS 6-bit character-ROM addresses, MSB character first.
//  Hex mode and decimal mode are both supported. Decimal uses a sequential double-dabble conversion.
//  Optional leading-zero blanking and overflow dashes.
//  Characters are streamed over a valid/ready handshake to the VGA text-overlay writer.
// PARAMETERS
//  VALUE_WIDTH  16  width of input value (>=4)
//  NUM_CHARS    4   characters emitted per conversion (>=1)
// PORTS
//  Clock             in   1                      system clock, rising edge
//  Resetn            in   1                      asynchronous active-low reset
//  Start             in   1                      request conversion; sampled only when Busy=0
//  Value             in   VALUE_WIDTH            value, captured on accepted Start
//  Mode_decimal      in   1                      0=hex, 1=decimal; captured with Start
//  Blank_zeros       in   1                      1=leading zeros -> space; captured with Start
//  Busy              out  1                      high from accepted Start until last char accepted
//  Char_valid        out  1                      Char_rom_address/Char_index/Char_last valid
//  Char_ready        in   1                      downstream accepts char when Char_valid & Char_ready
//  Char_rom_address  out  6                      character-ROM address
//  Char_index        out  $clog2(NUM_CHARS)|1    0 = most significant char
//  Char_last         out  1                      high with index NUM_CHARS-1
//  Overflow          out  1                      value did not fit; held until next accepted Start
// BEHAVIOUR
//  Reset: state IDLE; Busy=0, Char_valid=0, Char_rom_address=0, Char_index=0, Char_last=0, Overflow=0.
//    Reset is asynchronous and may assert mid-conversion or mid-emit; it aborts cleanly, and no partial string resumes.
//  FSM states:
//    IDLE: on Start, capture Value/Mode/Blank and clear Overflow. Hex -> EMIT; decimal -> CONVERT.
//    CONVERT: one double-dabble step per cycle over NUM_CHARS BCD digits (add 3 to each digit >=5, then shift in Value MSB).
//      Takes exactly VALUE_WIDTH cycles, then -> EMIT.
//    EMIT: presents char index 0..NUM_CHARS-1. Index advances only on Char_valid & Char_ready.
//      Acceptance of the last char -> IDLE with Busy=0 in the same edge.
//  Start is ignored while Busy=1. Start in the same cycle as the final acceptance is also ignored.
//  Latency: Start accepted at edge k.
//    Hex: Char_valid=1 after edge k+1.
//    Decimal: Char_valid=1 after edge k+1+VALUE_WIDTH.
//  Outputs are registered. While Char_valid & !Char_ready, all char outputs are held stable.
//  Digit map: d in 0..15 -> 6'o60+d (0-9 = 6'o60-6'o71, A-F = 6'o72-6'o77). Space = 6'o40. Dash = 6'o55.
//  Hex overflow: NUM_CHARS*4 < VALUE_WIDTH and any truncated upper bit = 1.
//  Decimal overflow: any 1 shifted out of the top BCD digit during CONVERT.
//  On overflow: all NUM_CHARS chars = dash; Overflow=1 from entry to EMIT.
//  Hex digits beyond VALUE_WIDTH (NUM_CHARS*4 > VALUE_WIDTH) read as 0.
//  Blanking (Blank_zeros=1, no overflow): a zero digit becomes space if every more-significant digit is zero.
//    The last char is never blanked, so value 0 -> spaces then 6'o60.
// STRUCTURE
//  Package char_gen_pkg holds:
//    - constants CHAR_DIGIT_BASE=6'o60, CHAR_SPACE=6'o40, CHAR_DASH=6'o55
//    - typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT} char_gen_state_t
//    - function digit_to_char_addr(logic [3:0]) -> logic [5:0]
//  Sub-module double_dabble_converter holds the VALUE_WIDTH-cycle BCD shifter.
//    Ports: Clock, Resetn, load, Value, bcd[4*NUM_CHARS-1:0], done, overflow.
//  Top level holds the FSM, digit selection, blanking and handshake.
// TESTING (VALUE_WIDTH=16, NUM_CHARS=4, Char_ready=1 unless stated)
//  Hex 16'hBEEF, no blank:
//    -> 6'o73,6'o76,6'o76,6'o77 on 4 consecutive cycles, Char_last on 4th, Overflow=0.
//  Decimal 16'd1234:
//    -> Char_valid first after 17 edges; 6'o61,6'o62,6'o63,6'o64.
//  Decimal 16'd7, Blank_zeros=1:
//    -> 6'o40,6'o40,6'o40,6'o67.
//  Value 0, hex, blank:
//    -> 6'o40 x3 then 6'o60.
//  Decimal 16'd12345:
//    -> 6'o55 x4, Overflow=1; Overflow clears on next accepted Start.
//  Backpressure and Start while busy:
//    Char_ready=0 for 3 cycles at index 1 -> outputs held, index still 1.
//    Start pulsed while Busy=1 -> ignored.
//  Reset mid-decimal:
//    Resetn low during CONVERT -> all outputs 0 immediately.
//    Next Start 16'h00A5 hex -> 6'o60,6'o60,6'o72,6'o65.

Source files
------------

// File: rtl/char_gen_pkg.sv
// Shared constants, FSM state type and digit mapping for the numeric-string
// character-address generator.
package char_gen_pkg;

    localparam logic [5:0] CHAR_DIGIT_BASE = 6'o60;
    localparam logic [5:0] CHAR_SPACE      = 6'o40;
    localparam logic [5:0] CHAR_DASH       = 6'o55;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_EMIT
    } char_gen_state_t;

    // Digits 0-9 and A-F occupy one contiguous run of the character ROM.
    function automatic logic [5:0] digit_to_char_addr(input logic [3:0] digit);
        return CHAR_DIGIT_BASE + 6'(digit);
    endfunction

endpackage

// File: rtl/double_dabble_converter.sv
// Sequential binary-to-BCD converter: one add-3/shift step per cycle,
// VALUE_WIDTH steps after load, with sticky overflow from the top digit.
module double_dabble_converter #(
    parameter int unsigned VALUE_WIDTH = 16,
    parameter int unsigned NUM_CHARS   = 4
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     load,
    input  logic [VALUE_WIDTH-1:0]   Value,
    output logic [4*NUM_CHARS-1:0]   bcd,
    output logic                     done,
    output logic                     overflow
);

    localparam int unsigned BCD_W = 4 * NUM_CHARS;
    localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);

    logic [VALUE_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]       step_q;
    logic                   active_q;
    logic [BCD_W-1:0]       adj_c;

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    always_comb begin
        adj_c = bcd;
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            shift_q  <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
            bcd      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            shift_q  <= Value;
            step_q   <= '0;
            active_q <= 1'b1;
            bcd      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (active_q) begin
            bcd      <= {adj_c[BCD_W-2:0], shift_q[VALUE_WIDTH-1]};
            shift_q  <= {shift_q[VALUE_WIDTH-2:0], 1'b0};
            overflow <= overflow | adj_c[BCD_W-1];
            step_q   <= step_q + CNT_W'(1);
            if (step_q == CNT_W'(VALUE_WIDTH - 1)) begin
                active_q <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_dec_string_char_addr_gen.sv
// Turns a binary value into a string of character-ROM addresses (hex or decimal),
// with optional leading-zero blanking and dash-filled overflow, streamed MSB first.
module hex_dec_string_char_addr_gen
    import char_gen_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 16,
    parameter int unsigned NUM_CHARS   = 4
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Start,
    input  logic [VALUE_WIDTH-1:0] Value,
    input  logic                   Mode_decimal,
    input  logic                   Blank_zeros,
    output logic                   Busy,
    output logic                   Char_valid,
    input  logic                   Char_ready,
    output logic [5:0]             Char_rom_address,
    output logic [((NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1)-1:0] Char_index,
    output logic                   Char_last,
    output logic                   Overflow
);

    localparam int unsigned DIGIT_BITS = 4 * NUM_CHARS;
    localparam int unsigned EXT_W      = (VALUE_WIDTH > DIGIT_BITS) ? VALUE_WIDTH : DIGIT_BITS;
    localparam int unsigned IDX_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    char_gen_state_t        state;
    logic [VALUE_WIDTH-1:0] value_q;
    logic                   mode_q;
    logic                   blank_q;

    logic                   dd_load_c;
    logic [DIGIT_BITS-1:0]  dd_bcd;
    logic                   dd_done;
    logic                   dd_overflow;

    logic [EXT_W-1:0]       start_ext_c;
    logic                   hex_ovf_c;
    logic [EXT_W-1:0]       value_ext_c;
    logic [DIGIT_BITS-1:0]  src_c;
    logic                   ovf_c;
    logic                   zero_run_c;
    logic [3:0]             digit_c;
    logic [5:0]             chars_c [NUM_CHARS];
    logic [IDX_W-1:0]       next_idx_c;

    assign dd_load_c = (state == S_IDLE) && Start && Mode_decimal;

    double_dabble_converter #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .NUM_CHARS   (NUM_CHARS)
    ) u_dd (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (dd_load_c),
        .Value    (Value),
        .bcd      (dd_bcd),
        .done     (dd_done),
        .overflow (dd_overflow)
    );

    // Hex overflow: any set bit above the displayable nibbles; missing nibbles read as 0.
    always_comb begin
        start_ext_c = EXT_W'(Value);
        hex_ovf_c   = |(start_ext_c >> DIGIT_BITS);
        value_ext_c = EXT_W'(value_q);
    end

    // Full string for the captured value; the decimal overflow flag is taken live
    // from the converter on the cycle the first character is loaded.
    always_comb begin
        src_c      = mode_q ? dd_bcd : value_ext_c[DIGIT_BITS-1:0];
        ovf_c      = (state == S_CONVERT) ? dd_overflow : Overflow;
        zero_run_c = 1'b1;
        digit_c    = '0;
        for (int i = 0; i < int'(NUM_CHARS); i++) begin
            digit_c    = src_c[4*(int'(NUM_CHARS) - 1 - i) +: 4];
            zero_run_c = zero_run_c && (digit_c == 4'd0);
            if (ovf_c) begin
                chars_c[i] = CHAR_DASH;
            end else if (blank_q && zero_run_c && (i != int'(NUM_CHARS) - 1)) begin
                chars_c[i] = CHAR_SPACE;
            end else begin
                chars_c[i] = digit_to_char_addr(digit_c);
            end
        end
    end

    assign next_idx_c = Char_valid ? (Char_index + IDX_W'(1)) : '0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state            <= S_IDLE;
            value_q          <= '0;
            mode_q           <= 1'b0;
            blank_q          <= 1'b0;
            Busy             <= 1'b0;
            Char_valid       <= 1'b0;
            Char_rom_address <= '0;
            Char_index       <= '0;
            Char_last        <= 1'b0;
            Overflow         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        value_q  <= Value;
                        mode_q   <= Mode_decimal;
                        blank_q  <= Blank_zeros;
                        Busy     <= 1'b1;
                        Overflow <= Mode_decimal ? 1'b0 : hex_ovf_c;
                        state    <= Mode_decimal ? S_CONVERT : S_EMIT;
                    end
                end
                S_CONVERT: begin
                    if (dd_done) begin
                        state            <= S_EMIT;
                        Overflow         <= dd_overflow;
                        Char_valid       <= 1'b1;
                        Char_rom_address <= chars_c[next_idx_c];
                        Char_index       <= next_idx_c;
                        Char_last        <= (next_idx_c == LAST_IDX);
                    end
                end
                S_EMIT: begin
                    // Load a new character on entry or after each accepted one; hold otherwise.
                    if (Char_valid && Char_ready && Char_last) begin
                        state      <= S_IDLE;
                        Busy       <= 1'b0;
                        Char_valid <= 1'b0;
                        Char_index <= '0;
                        Char_last  <= 1'b0;
                    end else if (!Char_valid || Char_ready) begin
                        Char_valid       <= 1'b1;
                        Char_rom_address <= chars_c[next_idx_c];
                        Char_index       <= next_idx_c;
                        Char_last        <= (next_idx_c == LAST_IDX);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_dec_string_char_addr_gen.sv
// Scoreboard bench for hex_dec_string_char_addr_gen (VALUE_WIDTH=16, NUM_CHARS=4).
module tb_hex_dec_string_char_addr_gen;

    typedef struct packed {
        logic [5:0] addr;
        logic [1:0] idx;
        logic       last;
        logic       ovf;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic [15:0] Value;
    logic        Mode_decimal;
    logic        Blank_zeros;
    logic        Busy;
    logic        Char_valid;
    logic        Char_ready;
    logic [5:0]  Char_rom_address;
    logic [1:0]  Char_index;
    logic        Char_last;
    logic        Overflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 Clock = ~Clock;

    hex_dec_string_char_addr_gen #(
        .VALUE_WIDTH (16),
        .NUM_CHARS   (4)
    ) dut (
        .Clock            (Clock),
        .Resetn           (Resetn),
        .Start            (Start),
        .Value            (Value),
        .Mode_decimal     (Mode_decimal),
        .Blank_zeros      (Blank_zeros),
        .Busy             (Busy),
        .Char_valid       (Char_valid),
        .Char_ready       (Char_ready),
        .Char_rom_address (Char_rom_address),
        .Char_index       (Char_index),
        .Char_last        (Char_last),
        .Overflow         (Overflow)
    );

    // Every accepted character is matched against the head of the scoreboard.
    exp_t mon_e;
    always @(negedge Clock) begin
        if (Resetn && Char_valid && Char_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_char got addr=%o idx=%0d last=%0b ovf=%0b, required none",
                         Char_rom_address, Char_index, Char_last, Overflow);
            end else begin
                mon_e = exp_q.pop_front();
                if ({Char_rom_address, Char_index, Char_last, Overflow} !== mon_e) begin
                    failures++;
                    $display("FAIL char got addr=%o idx=%0d last=%0b ovf=%0b, required addr=%o idx=%0d last=%0b ovf=%0b",
                             Char_rom_address, Char_index, Char_last, Overflow,
                             mon_e.addr, mon_e.idx, mon_e.last, mon_e.ovf);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic push_const(input logic [5:0] a0, input logic [5:0] a1,
                              input logic [5:0] a2, input logic [5:0] a3, input logic ovf);
        logic [5:0] a [4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        for (int i = 0; i < 4; i++) exp_q.push_back('{a[i], 2'(i), (i == 3), ovf});
    endtask

    // Reference model: arithmetic division for decimal, nibble extraction for hex.
    task automatic push_model(input logic [15:0] v, input logic mode, input logic blank);
        int dig [4];
        int t;
        logic ovf;
        logic lz;
        logic [5:0] a;
        ovf = 1'b0;
        if (mode) begin
            ovf = (v >= 16'd10000);
            t = int'(v);
            for (int i = 3; i >= 0; i--) begin
                dig[i] = t % 10;
                t = t / 10;
            end
        end else begin
            for (int i = 0; i < 4; i++) dig[i] = int'((v >> (4 * (3 - i))) & 16'hF);
        end
        lz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (dig[i] != 0) lz = 1'b0;
            if (ovf) a = 6'o55;
            else if (blank && lz && i < 3) a = 6'o40;
            else a = 6'(48 + dig[i]);
            exp_q.push_back('{a, 2'(i), (i == 3), ovf});
        end
    endtask

    task automatic start_conv(input logic [15:0] v, input logic mode, input logic blank);
        @(negedge Clock);
        Value = v; Mode_decimal = mode; Blank_zeros = blank; Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 500) begin
            @(posedge Clock); #1;
            n++;
        end
    endtask

    task automatic measure_latency(output int n);
        n = 0;
        while (!Char_valid && n < 100) begin
            @(posedge Clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Start = 1'b0; Value = '0; Mode_decimal = 1'b0;
        Blank_zeros = 1'b0; Char_ready = 1'b1;
        #23;
        checks++;
        if ({Busy, Char_valid, Char_rom_address, Char_index, Char_last, Overflow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got %b, required all zero",
                     {Busy, Char_valid, Char_rom_address, Char_index, Char_last, Overflow});
        end
        @(negedge Clock) Resetn = 1'b1;
    endtask

    task automatic test_hex_beef();
        int lat;
        push_const(6'o73, 6'o76, 6'o76, 6'o77, 1'b0);
        start_conv(16'hBEEF, 1'b0, 1'b0);
        measure_latency(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL hex_latency got %0d, required 1", lat);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (Char_valid !== 1'b1 || Char_index !== 2'(j)) begin
                failures++;
                $display("FAIL hex_consecutive got valid=%0b idx=%0d, required valid=1 idx=%0d",
                         Char_valid, Char_index, j);
            end
            @(posedge Clock); #1;
        end
        checks++;
        if (Busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL hex_done got busy=%0b pending=%0d, required busy=0 pending=0",
                     Busy, exp_q.size());
        end
    endtask

    task automatic test_decimal_latency();
        int lat;
        push_const(6'o61, 6'o62, 6'o63, 6'o64, 1'b0);
        start_conv(16'd1234, 1'b1, 1'b0);
        measure_latency(lat);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL dec_latency got %0d, required 17", lat);
        end
        wait_idle();
        checks++;
        if (Busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL dec_done got busy=%0b pending=%0d, required busy=0 pending=0",
                     Busy, exp_q.size());
        end
    endtask

    task automatic test_blanking();
        push_const(6'o40, 6'o40, 6'o40, 6'o67, 1'b0);
        start_conv(16'd7, 1'b1, 1'b1);
        wait_idle();
        push_const(6'o40, 6'o40, 6'o40, 6'o60, 1'b0);
        start_conv(16'h0000, 1'b0, 1'b1);
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL blank_pending got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        push_const(6'o55, 6'o55, 6'o55, 6'o55, 1'b1);
        start_conv(16'd12345, 1'b1, 1'b1);
        wait_idle();
        checks++;
        if (Overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_held got %0b, required 1", Overflow);
        end
        push_model(16'h1234, 1'b0, 1'b0);
        start_conv(16'h1234, 1'b0, 1'b0);
        checks++;
        if (Overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got %0b, required 0", Overflow);
        end
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_pending got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int lat;
        Char_ready = 1'b0;
        push_model(16'h5A3C, 1'b0, 1'b0);
        start_conv(16'h5A3C, 1'b0, 1'b0);
        measure_latency(lat);
        Char_ready = 1'b1;
        @(posedge Clock); #1;
        Char_ready = 1'b0;
        Value = 16'hFFFF; Mode_decimal = 1'b1; Start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge Clock); #1;
            checks++;
            if (Char_valid !== 1'b1 || Char_index !== 2'd1 || Char_rom_address !== 6'o72 || Busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold got valid=%0b idx=%0d addr=%o busy=%0b, required valid=1 idx=1 addr=72 busy=1",
                         Char_valid, Char_index, Char_rom_address, Busy);
            end
        end
        Start = 1'b0;
        Char_ready = 1'b1;
        wait_idle();
        @(posedge Clock); #1;
        checks++;
        if (Busy !== 1'b0 || Char_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL busy_start_ignored got busy=%0b valid=%0b pending=%0d, required 0 0 0",
                     Busy, Char_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        push_model(16'h0F0F, 1'b0, 1'b1);
        start_conv(16'h0F0F, 1'b0, 1'b1);
        n = 0;
        while (!(Char_valid && Char_last) && n < 100) begin
            @(posedge Clock); #1;
            n++;
        end
        Value = 16'h4321; Mode_decimal = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (Busy !== 1'b0 || Char_valid !== 1'b0) begin
                failures++;
                $display("FAIL final_accept_start got busy=%0b valid=%0b, required busy=0 valid=0",
                         Busy, Char_valid);
            end
            @(posedge Clock); #1;
        end
        push_model(16'd905, 1'b1, 1'b1);
        start_conv(16'd905, 1'b1, 1'b1);
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_pending got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        push_model(16'd9999, 1'b1, 1'b0);
        start_conv(16'd9999, 1'b1, 1'b0);
        repeat (5) begin
            @(posedge Clock); #1;
        end
        Resetn = 1'b0;
        #1;
        checks++;
        if ({Busy, Char_valid, Char_rom_address, Char_index, Char_last, Overflow} !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset got %b, required all zero",
                     {Busy, Char_valid, Char_rom_address, Char_index, Char_last, Overflow});
        end
        exp_q.delete();
        @(negedge Clock) Resetn = 1'b1;
        push_const(6'o60, 6'o60, 6'o72, 6'o65, 1'b0);
        start_conv(16'h00A5, 1'b0, 1'b0);
        wait_idle();
        checks++;
        if (Busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset got busy=%0b pending=%0d, required busy=0 pending=0",
                     Busy, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic        m;
        logic        b;
        for (int k = 0; k < 10; k++) begin
            v = 16'($urandom);
            if (k % 3 == 0) v = v % 16'd100;
            m = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            push_model(v, m, b);
            start_conv(v, m, b);
            wait_idle();
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL random_pending value=%h mode=%0b got %0d, required 0", v, m, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex_beef();
        test_decimal_latency();
        test_blanking();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
